// File: rtl/fifo_wr_arbiter_ctrl_if.sv
// Write-side bundle of the async FIFO: producer handshake, synchronized read
// pointer, memory write port and fill-level status.
interface fifo_wr_arbiter_ctrl_if #(
  parameter int PTR_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 4
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic [PTR_WIDTH:0]         rptr_gray_sync;
  logic [PTR_WIDTH:0]         wptr_gray;
  logic                       mem_wen;
  logic [PTR_WIDTH-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [GW-1:0]              grant_id;
  logic                       full;
  logic                       almost_full;
  logic [PTR_WIDTH:0]         wr_count;

  // Producer/read-domain side.
  modport master (
    output req_valid, req_data, rptr_gray_sync,
    input  req_ready, wptr_gray, mem_wen, mem_waddr, mem_wdata,
           grant_id, full, almost_full, wr_count
  );

  // Controller side.
  modport slave (
    input  req_valid, req_data, rptr_gray_sync,
    output req_ready, wptr_gray, mem_wen, mem_waddr, mem_wdata,
           grant_id, full, almost_full, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter_ctrl.sv
// Async FIFO write-side controller: round-robin arbitration of NREQ producers
// onto the single write port, write pointer ownership and full/fill flags.
module fifo_wr_arbiter_ctrl #(
  parameter int PTR_WIDTH    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int NREQ         = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_wr_arbiter_ctrl_if.slave  bus
);
  localparam int GW    = $clog2(NREQ);
  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] AFULL_LEVEL = (PTR_WIDTH+1)'(DEPTH - AFULL_THRESH);

  logic [PTR_WIDTH:0] r_wbin;
  logic [PTR_WIDTH:0] r_wptr_gray;
  logic               r_full;
  logic               r_almost_full;
  logic [PTR_WIDTH:0] r_wr_count;
  logic [GW-1:0]      r_last_grant;

  logic [GW-1:0]      w_grant;
  logic               w_found;
  logic [NREQ-1:0]    w_ready;
  logic               w_xfer;
  logic [PTR_WIDTH:0] w_wbin_next;
  logic [PTR_WIDTH:0] w_wgray_next;
  logic [PTR_WIDTH:0] w_rbin;
  logic [PTR_WIDTH:0] w_count_next;
  logic               w_full_next;

  // Round-robin search starting just after the last producer that was served.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant = r_last_grant;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (int'(r_last_grant) + k) % NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_grant = GW'(idx);
        w_found = 1'b1;
      end
    end
  end

  // Ready is gated by rst directly so it drops the moment reset asserts.
  always_comb begin
    w_ready = '0;
    if (!rst && w_found && !r_full) w_ready[w_grant] = 1'b1;
  end

  assign w_xfer       = |w_ready;
  assign w_wbin_next  = r_wbin + (PTR_WIDTH+1)'(w_xfer);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) w_rbin[i] = ^(bus.rptr_gray_sync >> i);
  end

  // Full when the pointers differ only in wrap bit: in Gray form that is the top two bits inverted.
  assign w_full_next  = (w_wgray_next == {~bus.rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1],
                                          bus.rptr_gray_sync[PTR_WIDTH-2:0]});
  assign w_count_next = w_wbin_next - w_rbin;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin        <= '0;
      r_wptr_gray   <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wr_count    <= '0;
      r_last_grant  <= GW'(NREQ - 1);
    end else begin
      r_wbin        <= w_wbin_next;
      r_wptr_gray   <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= (w_count_next >= AFULL_LEVEL);
      r_wr_count    <= w_count_next;
      if (w_xfer) r_last_grant <= w_grant;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.mem_wen     = w_xfer;
  assign bus.mem_waddr   = r_wbin[PTR_WIDTH-1:0];
  assign bus.mem_wdata   = bus.req_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id    = w_grant;
  assign bus.wptr_gray   = r_wptr_gray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.wr_count    = r_wr_count;
endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Self-checking bench for fifo_wr_arbiter_ctrl: directed vector table, corner
// sequences, and randomized traffic against a pointer-arithmetic model.
module tb_fifo_wr_arbiter_ctrl;
  localparam int PW    = 4;
  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int AT    = 2;
  localparam int DEPTH = 1 << PW;
  localparam int PMOD  = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_ctrl_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .NREQ(NR)) bus ();

  fifo_wr_arbiter_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .NREQ(NR), .AFULL_THRESH(AT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] d [NR];

  typedef struct {
    logic [NR-1:0] valid;
    int            grant;
    logic [NR-1:0] ready;
    int            waddr;
    int            count;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
  endtask

  task automatic new_data();
    for (int i = 0; i < NR; i++) d[i] = DW'($urandom);
    drive_data();
  endtask

  function automatic logic [PW:0] to_gray(input int b);
    logic [PW:0] v;
    v = (PW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid      = NR'($urandom);
    bus.rptr_gray_sync = (PW+1)'($urandom);
    new_data();
    #1;
    check("rst_ready",  32'(bus.req_ready), 0);
    check("rst_wen",    32'(bus.mem_wen), 0);
    check("rst_full",   32'(bus.full), 0);
    check("rst_afull",  32'(bus.almost_full), 0);
    check("rst_count",  32'(bus.wr_count), 0);
    check("rst_wptr",   32'(bus.wptr_gray), 0);
    check("rst_waddr",  32'(bus.mem_waddr), 0);
    @(negedge clk);
    bus.req_valid      = '0;
    bus.rptr_gray_sync = '0;
    rst = 1'b0;
  endtask

  // Writes n words from producer p with the read pointer parked at zero.
  task automatic fill_from(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_valid = NR'(1 << p);
      new_data();
      #1;
      check("fill_ready", 32'(bus.req_ready), 32'(1 << p));
      check("fill_waddr", 32'(bus.mem_waddr), 32'(i % DEPTH));
      check("fill_wdata", 32'(bus.mem_wdata), 32'(d[p]));
      @(posedge clk); #1;
      check("fill_count", 32'(bus.wr_count), 32'(i + 1));
      check("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= DEPTH - AT));
      check("fill_full",  32'(bus.full), 32'((i + 1) == DEPTH));
    end
  endtask

  // Reference model state for the random phase.
  int            m_wbin, m_rbin, m_last, m_cnt;
  logic          m_full;
  logic [NR-1:0] pend;

  initial begin
    vecs[0] = '{4'b1111, 0, 4'b0001, 0, 1};
    vecs[1] = '{4'b1111, 1, 4'b0010, 1, 2};
    vecs[2] = '{4'b0001, 0, 4'b0001, 2, 3};
    vecs[3] = '{4'b0000, 0, 4'b0000, 3, 3};
    vecs[4] = '{4'b1000, 3, 4'b1000, 3, 4};
    vecs[5] = '{4'b0110, 1, 4'b0010, 4, 5};
    vecs[6] = '{4'b0110, 2, 4'b0100, 5, 6};
    vecs[7] = '{4'b0011, 0, 4'b0001, 6, 7};

    bus.req_valid = '0;
    bus.rptr_gray_sync = '0;
    new_data();

    // Directed arbitration table straight out of reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].valid;
      new_data();
      #1;
      check("tbl_grant", 32'(bus.grant_id), 32'(vecs[i].grant));
      check("tbl_ready", 32'(bus.req_ready), 32'(vecs[i].ready));
      check("tbl_wen",   32'(bus.mem_wen), 32'(vecs[i].ready != 0));
      check("tbl_waddr", 32'(bus.mem_waddr), 32'(vecs[i].waddr));
      if (vecs[i].ready != 0) check("tbl_wdata", 32'(bus.mem_wdata), 32'(d[vecs[i].grant]));
      @(posedge clk); #1;
      check("tbl_count", 32'(bus.wr_count), 32'(vecs[i].count));
    end

    // Fill to full from producer 2, then confirm the overflow write is refused.
    do_reset();
    fill_from(2, DEPTH);
    check("full_wptr", 32'(bus.wptr_gray), 32'h18);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    check("full_ready", 32'(bus.req_ready), 0);
    check("full_wen",   32'(bus.mem_wen), 0);
    // Read side reports binary 4: full clears on the next edge.
    bus.rptr_gray_sync = 5'b00110;
    @(posedge clk); #1;
    check("drain_full",  32'(bus.full), 0);
    check("drain_count", 32'(bus.wr_count), 12);
    check("drain_afull", 32'(bus.almost_full), 0);
    @(negedge clk); #1;
    check("drain_ready", 32'(bus.req_ready), 32'h4);
    check("drain_waddr", 32'(bus.mem_waddr), 0);
    @(posedge clk); #1;
    check("drain_count2", 32'(bus.wr_count), 13);

    // Continuous contention: strict rotation 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req_valid = '1;
      new_data();
      #1;
      check("rr_grant", 32'(bus.grant_id), 32'(i % NR));
      check("rr_wdata", 32'(bus.mem_wdata), 32'(d[i % NR]));
      @(posedge clk);
    end

    // Async reset mid-burst, checked before any clock edge can occur.
    do_reset();
    fill_from(2, 9);
    @(negedge clk);
    bus.req_valid = '1;
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.wr_count), 0);
    check("arst_wptr",  32'(bus.wptr_gray), 0);
    check("arst_ready", 32'(bus.req_ready), 0);
    check("arst_wen",   32'(bus.mem_wen), 0);
    check("arst_waddr", 32'(bus.mem_waddr), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_grant", 32'(bus.grant_id), 0);
    check("arst_ready1", 32'(bus.req_ready), 32'h1);
    check("arst_waddr1", 32'(bus.mem_waddr), 0);
    @(posedge clk); #1;
    check("arst_count1", 32'(bus.wr_count), 1);

    // Randomized traffic against the pointer-arithmetic model; spans several wraps.
    do_reset();
    m_wbin = 0; m_rbin = 0; m_last = NR - 1; m_full = 1'b0; pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int            g;
      logic          any;
      logic [NR-1:0] exp_ready;
      logic [PW:0]   prev_gray;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          d[i]    = DW'($urandom);
        end
      end
      if (((m_wbin - m_rbin + PMOD) % PMOD) != 0 && ($urandom % 3 == 0))
        m_rbin = (m_rbin + 1) % PMOD;
      bus.req_valid      = pend;
      bus.rptr_gray_sync = to_gray(m_rbin);
      drive_data();
      #1;
      g   = m_last;
      any = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        if (!any && pend[(m_last + k) % NR]) begin
          g   = (m_last + k) % NR;
          any = 1'b1;
        end
      end
      exp_ready = (any && !m_full) ? NR'(1 << g) : '0;
      check("rnd_grant", 32'(bus.grant_id), 32'(g));
      check("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("rnd_waddr", 32'(bus.mem_waddr), 32'(m_wbin % DEPTH));
      if (exp_ready != 0) check("rnd_wdata", 32'(bus.mem_wdata), 32'(d[g]));
      prev_gray = bus.wptr_gray;
      @(posedge clk); #1;
      if (exp_ready != 0) begin
        m_wbin  = (m_wbin + 1) % PMOD;
        m_last  = g;
        pend[g] = 1'b0;
      end
      m_cnt  = (m_wbin - m_rbin + PMOD) % PMOD;
      m_full = (m_cnt == DEPTH);
      check("rnd_count", 32'(bus.wr_count), 32'(m_cnt));
      check("rnd_full",  32'(bus.full), 32'(m_full));
      check("rnd_afull", 32'(bus.almost_full), 32'(m_cnt >= DEPTH - AT));
      check("rnd_wptr",  32'(bus.wptr_gray), 32'(to_gray(m_wbin)));
      check("rnd_gray_step", 32'($countones(prev_gray ^ bus.wptr_gray)), 32'(exp_ready != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter_ctrl.md
Name: fifo_wr_arbiter_ctrl

Overview:
Write-side controller for the async FIFO. It shares the single FIFO write port among NREQ producers using round-robin arbitration. It owns the write pointer in binary and Gray form, drives the dual-port memory write interface, and generates the full, almost_full and fill-count indications. It compares its write pointer against the read pointer after that pointer has passed through the 2-flop synchronizer into the write clock domain.

Parameters:
PTR_WIDTH, 4, address width; FIFO depth = 2**PTR_WIDTH; minimum 2
DATA_WIDTH, 8, word width
NREQ, 4, number of producers; minimum 2
AFULL_THRESH, 2, almost_full asserts when free slots <= AFULL_THRESH

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-producer word valid
req_data  in  NREQ*DATA_WIDTH  packed words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NREQ  per-producer accept, one-hot or zero
rptr_gray_sync  in  PTR_WIDTH+1  read pointer (Gray), already synchronized into clk domain
wptr_gray  out  PTR_WIDTH+1  write pointer (Gray), registered, sent to the read-domain synchronizer
mem_wen  out  1  memory write enable
mem_waddr  out  PTR_WIDTH  memory write address
mem_wdata  out  DATA_WIDTH  memory write data
grant_id  out  $clog2(NREQ)  index of the currently granted producer
full  out  1  registered full flag
almost_full  out  1  registered almost-full flag
wr_count  out  PTR_WIDTH+1  registered, conservative fill level

Behaviour:
- Reset (async assert, sync-free): wbin=0, wptr_gray=0, full=0, almost_full=0, wr_count=0, last_grant=NREQ-1.
- While rst is high: req_ready=0 and mem_wen=0.
- Arbitration (combinational):
  - Search req_valid starting at index (last_grant+1) mod NREQ, wrapping.
  - The first valid index found is the grant; grant_id = that index, or last_grant if nothing is valid.
  - req_ready[grant] = req_valid[grant] & ~full. All other req_ready bits are 0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] in a cycle.
  - Same cycle: mem_wen=1, mem_waddr=wbin[PTR_WIDTH-1:0], mem_wdata=req_data of the granted producer. Zero-cycle write latency.
  - Producers hold valid and data until ready is seen.
- Clock edge after a transfer:
  - wbin <= wbin+1, wrapping mod 2**(PTR_WIDTH+1).
  - wptr_gray <= wbin_next ^ (wbin_next>>1).
  - last_grant <= grant.
  - With no transfer, last_grant holds. Fairness advances only on accepted words.
- Flags are registered from wbin_next and the current rptr_gray_sync:
  - full_next = (gray(wbin_next) == {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_sync[PTR_WIDTH-2:0]}).
  - rbin = Gray-to-binary(rptr_gray_sync).
  - wr_count_next = wbin_next - rbin, mod 2**(PTR_WIDTH+1).
  - almost_full_next = wr_count_next >= 2**PTR_WIDTH - AFULL_THRESH.
- Boundaries:
  - Write at count = DEPTH-1: full asserts on the next edge, so an overflow write is impossible.
  - A write is never accepted while full=1.
  - Read pointer advancing while full: full deasserts one edge after rptr_gray_sync changes.
  - A simultaneous write and read-pointer update are both reflected in the same registered wr_count.
  - wr_count is pessimistic due to synchronizer lag: it never under-reports fill.
  - Pointer wrap: after 2**(PTR_WIDTH+1) writes, wbin returns to 0. The Gray code changes exactly 1 bit per increment, including at the wrap.
  - Reset mid-burst: all state clears immediately and req_ready drops asynchronously. The first grant after release goes to producer 0.

Test Plan:
- Reset: assert rst with random inputs -> all outputs 0, req_ready=0; first grant after release is producer 0.
- Fill (default params, rptr_gray_sync=0, only producer 2 valid):
  - 16 accepted words with mem_waddr 0..15 -> full=1 after 16th edge, wptr_gray=5'b11000, wr_count=16, req_ready[2]=0.
  - almost_full=1 from wr_count=14.
- Round robin: all 4 producers valid continuously, not full -> grant_id sequence 0,1,2,3,0,1; each mem_wdata matches the granted producer's data.
- Drain while full: set rptr_gray_sync=5'b00110 (binary 4) -> next edge full=0, wr_count=12, almost_full=0; the next write goes to mem_waddr 0.
- Wrap: 32 writes with the read pointer tracking -> wbin wraps to 0; wptr_gray changes exactly one bit per write; no false full.
- Async reset at wr_count=9 mid-burst -> outputs clear without a clock edge; fill restarts at address 0.
